adder_share_arbiter: RTL and testbench
======================================

Name: adder_share_arbiter

Overview:
- Shares one 16-bit carry adder (parallel_carry_adder_16bit) between NUM_REQ requesters using round-robin arbitration.
- Supports multi-word (chained) additions: a requester that issues a word with last=0 keeps the adder locked, and the carry propagates word to word.
- Sum is registered; one accepted word per cycle maximum.
- Sits between the arithmetic clients and the adder datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ), width of the requester index.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  per-requester request; operands are valid while high.
- req_a  input  NUM_REQ*16  operand A, requester i in bits [16i+15:16i].
- req_b  input  NUM_REQ*16  operand B, same packing.
- req_cin  input  NUM_REQ  carry-in for the first word of an operation.
- req_last  input  NUM_REQ  high = this word ends the operation.
- ack  output  NUM_REQ  one-hot grant, combinational; a word is accepted at a clock edge where req[i] and ack[i] are both high.
- rsp_valid  output  1  result valid, one cycle after acceptance.
- rsp_id  output  ID_W  requester index of the result.
- sum  output  16  registered sum.
- c_out  output  1  registered carry-out.

Behaviour:
- Reset, asynchronous and immediate:
  - rsp_valid=0, rsp_id=0, sum=0, c_out=0.
  - State=IDLE, rr pointer=0, stored carry=0.
  - ack is 0 for the duration of reset.
- States:
  - IDLE: no lock.
  - LOCKED(owner): a chain is in progress.
- IDLE grant rule:
  - ack goes to the first i with req[i]=1, searching from the pointer upward with wrap-around.
  - If no req is high, ack=0.
- LOCKED grant rule:
  - ack[owner]=req[owner]; every other ack=0.
  - If the owner drops req, the adder idles (bubble) and the lock is held. There is no timeout.
- Carry selection for an accepted word:
  - IDLE: req_cin[i] is used.
  - LOCKED: the stored carry is used and req_cin is ignored.
- On acceptance from requester i:
  - Register {c_out,sum} = req_a_i + req_b_i + selected carry, 17-bit result, modulo 2^17.
  - Set rsp_valid=1 and rsp_id=i on the next cycle.
  - Stored carry <= c_out of this word.
- Transitions on acceptance:
  - IDLE, last=0 -> LOCKED(i).
  - IDLE, last=1 -> stay IDLE; pointer <= (i+1) mod NUM_REQ.
  - LOCKED, last=0 -> stay LOCKED.
  - LOCKED, last=1 -> IDLE; pointer <= (owner+1) mod NUM_REQ; stored carry <= 0.
- No acceptance in a cycle: rsp_valid=0 next cycle; sum, c_out and rsp_id hold their last values.
- Latency: exactly 1 cycle from acceptance edge to rsp_valid. Throughput: 1 word/cycle, back-to-back from the same or different requesters.
- Requester protocol:
  - req_a, req_b, req_cin and req_last must be stable while req is high and ack is low.
  - Keeping req high after acceptance presents the next word.
- Pointer wrap: pointer NUM_REQ-1 advances to 0.
- Reset mid-chain: the lock, stored carry and any pending rsp_valid are discarded. The first word after reset uses req_cin.
- No arithmetic overflow flag is produced; c_out is the only overflow indication.

Decomposition:
- Shared package, adder_share_pkg:
  - DATA_W=16 constant.
  - State enum {IDLE, LOCKED}.
  - Function computing the round-robin one-hot from (req, pointer).
- One natural sub-module, rr_arbiter_onehot: combinational round-robin priority select, parameterised by NUM_REQ, pointer input.
- The adder itself is an instance of parallel_carry_adder_16bit, driven by muxed operands.

Test Plan:
- Single-word carry-out: req[0], a=0xFFFF, b=0x0001, cin=0, last=1 -> ack[0] same cycle; next cycle rsp_valid=1, rsp_id=0, sum=0x0000, c_out=1.
- Single-word carry-in: req[2], a=0x1234, b=0x4321, cin=1, last=1 -> sum=0x5556, c_out=0, rsp_id=2; pointer becomes 3.
- Chain with competitor:
  - req[1] issues word0 (0xFFFF+0x0001, cin=0, last=0), then word1 (0x0000+0x0000, req_cin=0, last=1).
  - req[3] is held high throughout.
  - Expected: results sum=0x0000/c_out=1, then sum=0x0001/c_out=0. ack[3] is 0 until the chain ends, then asserts in the next cycle.
- Round-robin fairness: all four req held high with single-word ops -> ack sequence 0,1,2,3,0,1 on consecutive cycles; rsp_valid continuously 1.
- Owner bubble: locked owner 0 drops req for 3 cycles while req[1]=1 -> ack=0 and rsp_valid=0 for those cycles. Owner resumes with last=1 and the stored carry is applied.
- Reset mid-chain: assert rst after word0 (c_out=1) of a chain -> outputs zero immediately. After release, a new op 0x0001+0x0001 with cin=0 gives sum=0x0002 (stored carry not applied); the arbiter starts at requester 0.

Source files
------------

// File: rtl/adder_share_pkg.sv
// Shared definitions for the adder-sharing arbiter: datapath width, lock
// state encoding and the round-robin one-hot select.
package adder_share_pkg;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned MAX_REQ = 8;
    localparam int unsigned PTR_W   = 3;

    typedef enum logic [0:0] {
        StIdle,
        StLocked
    } state_e;

    // First requester at or after ptr (wrapping over n entries), as a one-hot vector.
    function automatic logic [MAX_REQ-1:0] rr_onehot(
        input logic [MAX_REQ-1:0] req,
        input logic [PTR_W-1:0]   ptr,
        input int unsigned        n
    );
        logic [MAX_REQ-1:0] gnt;
        logic               found;
        logic [31:0]        idx;
        gnt   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            idx = (32'(ptr) + k) % n;
            if (k < n && !found && req[idx[PTR_W-1:0]]) begin
                gnt[idx[PTR_W-1:0]] = 1'b1;
                found               = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/adder_share_arbiter_if.sv
// Client-side bundle of the shared adder: packed per-requester operands,
// one-hot grant and the registered result.
interface adder_share_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
);
    import adder_share_pkg::*;

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ-1:0]        req_cin;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        ack;
    logic                      rsp_valid;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         sum;
    logic                      c_out;

    modport master (
        output req, req_a, req_b, req_cin, req_last,
        input  ack, rsp_valid, rsp_id, sum, c_out
    );

    modport slave (
        input  req, req_a, req_b, req_cin, req_last,
        output ack, rsp_valid, rsp_id, sum, c_out
    );

endinterface

// File: rtl/parallel_carry_adder_16bit.sv
// 16-bit adder with Kogge-Stone parallel carry computation.
module parallel_carry_adder_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in,
    output logic [15:0] sum,
    output logic        c_out
);

    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] gg;
    logic [15:0] pp;
    logic [15:0] gl;
    logic [15:0] pl;
    logic [16:0] c;

    // Prefix tree: gg[i]/pp[i] become generate/propagate over bits [i:0].
    always_comb begin
        g  = a & b;
        p  = a ^ b;
        gg = g;
        pp = p;
        gl = '0;
        pl = '0;
        for (int d = 1; d < 16; d = d * 2) begin
            gl = gg;
            pl = pp;
            for (int i = 0; i < 16; i++) begin
                if (i >= d) begin
                    gg[i] = gl[i] | (pl[i] & gl[i-d]);
                    pp[i] = pl[i] & pl[i-d];
                end
            end
        end
        c[0] = c_in;
        for (int i = 0; i < 16; i++) begin
            c[i+1] = gg[i] | (pp[i] & c_in);
        end
        sum   = p ^ c[15:0];
        c_out = c[16];
    end

endmodule

// File: rtl/rr_arbiter_onehot.sv
// Combinational round-robin priority select starting at a pointer.
module rr_arbiter_onehot
    import adder_share_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt
);

    logic [MAX_REQ-1:0] gnt_full;
    logic               unused_gnt_hi;

    // Widen to the package's fixed span, then keep only the live requesters.
    always_comb begin
        gnt_full = rr_onehot(MAX_REQ'(req), PTR_W'(ptr), NUM_REQ);
        gnt      = gnt_full[NUM_REQ-1:0];
    end

    assign unused_gnt_hi = ^gnt_full;

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin sharing of one 16-bit adder between NUM_REQ clients, with
// chained multi-word operations that lock the adder and carry word to word.
module adder_share_arbiter
    import adder_share_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input logic                 clk,
    input logic                 rst,
    adder_share_arbiter_if.slave bus
);

    state_e              state_q;
    logic [ID_W-1:0]     owner_q;
    logic [ID_W-1:0]     ptr_q;
    logic                carry_q;
    logic                rsp_valid_q;
    logic [ID_W-1:0]     rsp_id_q;
    logic [DATA_W-1:0]   sum_q;
    logic                c_out_q;

    logic [NUM_REQ-1:0]  rr_gnt;
    logic [NUM_REQ-1:0]  ack;
    logic                accept;
    logic [ID_W-1:0]     sel_id;
    logic [ID_W-1:0]     ptr_next;
    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b;
    logic                op_cin;
    logic                op_last;
    logic [DATA_W-1:0]   add_sum;
    logic                add_cout;

    rr_arbiter_onehot #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req (bus.req),
        .ptr (ptr_q),
        .gnt (rr_gnt)
    );

    // Grant: a lock reserves the adder for its owner even while the owner is silent.
    always_comb begin
        ack = '0;
        if (!rst) begin
            if (state_q == StLocked) begin
                ack[owner_q] = bus.req[owner_q];
            end else begin
                ack = rr_gnt;
            end
        end
    end

    // Operand mux from the granted requester; chained words take the stored carry.
    always_comb begin
        sel_id  = '0;
        op_a    = '0;
        op_b    = '0;
        op_cin  = 1'b0;
        op_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ack[i]) begin
                sel_id  = ID_W'(i);
                op_a    = bus.req_a[i*DATA_W +: DATA_W];
                op_b    = bus.req_b[i*DATA_W +: DATA_W];
                op_cin  = bus.req_cin[i];
                op_last = bus.req_last[i];
            end
        end
        if (state_q == StLocked) begin
            op_cin = carry_q;
        end
        accept   = |ack;
        ptr_next = (sel_id == ID_W'(NUM_REQ - 1)) ? '0 : sel_id + 1'b1;
    end

    parallel_carry_adder_16bit u_adder (
        .a     (op_a),
        .b     (op_b),
        .c_in  (op_cin),
        .sum   (add_sum),
        .c_out (add_cout)
    );

    // Lock FSM, round-robin pointer, stored carry and registered result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            owner_q     <= '0;
            ptr_q       <= '0;
            carry_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            sum_q       <= '0;
            c_out_q     <= 1'b0;
        end else begin
            rsp_valid_q <= accept;
            if (accept) begin
                sum_q    <= add_sum;
                c_out_q  <= add_cout;
                rsp_id_q <= sel_id;
                carry_q  <= add_cout;
                unique case (state_q)
                    StIdle: begin
                        if (op_last) begin
                            ptr_q <= ptr_next;
                        end else begin
                            state_q <= StLocked;
                            owner_q <= sel_id;
                        end
                    end
                    StLocked: begin
                        if (op_last) begin
                            state_q <= StIdle;
                            ptr_q   <= ptr_next;
                            carry_q <= 1'b0;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign bus.ack       = ack;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.sum       = sum_q;
    assign bus.c_out     = c_out_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Bench for adder_share_arbiter: directed scenarios plus protocol-respecting
// random traffic, all checked against a transaction-level reference model.
module tb_adder_share_arbiter;
    import adder_share_pkg::*;

    localparam int unsigned N = 4;

    logic clk = 1'b0;
    logic rst;

    adder_share_arbiter_if #(.NUM_REQ(N)) bus ();

    adder_share_arbiter #(.NUM_REQ(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit          m_locked;
    int          m_owner;
    int          m_ptr;
    logic        m_carry;
    logic [N-1:0] exp_ack;
    logic        exp_valid;
    logic [1:0]  exp_id;
    logic [15:0] exp_sum;
    logic        exp_cout;

    // Observed DUT values
    logic [N-1:0] obs_ack;
    logic        obs_valid;
    logic [1:0]  obs_id;
    logic [15:0] obs_sum;
    logic        obs_cout;

    task automatic model_reset();
        m_locked  = 1'b0;
        m_owner   = 0;
        m_ptr     = 0;
        m_carry   = 1'b0;
        exp_ack   = '0;
        exp_valid = 1'b0;
        exp_id    = '0;
        exp_sum   = '0;
        exp_cout  = 1'b0;
    endtask

    // One clock of the model: grant decision, arithmetic and lock bookkeeping.
    function automatic void model_step();
        int          g;
        int          idx;
        logic        ci;
        logic [16:0] tot;
        g       = -1;
        exp_ack = '0;
        if (m_locked) begin
            if (bus.req[m_owner]) g = m_owner;
        end else begin
            for (int k = 0; k < int'(N); k++) begin
                idx = (m_ptr + k) % int'(N);
                if (g < 0 && bus.req[idx]) g = idx;
            end
        end
        exp_valid = 1'b0;
        if (g >= 0) begin
            exp_ack[g] = 1'b1;
            ci  = m_locked ? m_carry : bus.req_cin[g];
            tot = {1'b0, bus.req_a[g*16 +: 16]} + {1'b0, bus.req_b[g*16 +: 16]} + {16'd0, ci};
            exp_sum   = tot[15:0];
            exp_cout  = tot[16];
            exp_valid = 1'b1;
            exp_id    = 2'(g);
            if (bus.req_last[g]) begin
                m_locked = 1'b0;
                m_carry  = 1'b0;
                m_ptr    = (g + 1) % int'(N);
            end else begin
                m_locked = 1'b1;
                m_owner  = g;
                m_carry  = tot[16];
            end
        end
    endfunction

    function automatic logic [15:0] rnd16();
        return ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
    endfunction

    task automatic set_word(input int i, input logic [15:0] a, input logic [15:0] b,
                            input logic cin, input logic last, input logic rq);
        bus.req[i]           = rq;
        bus.req_a[i*16 +: 16] = a;
        bus.req_b[i*16 +: 16] = b;
        bus.req_cin[i]       = cin;
        bus.req_last[i]      = last;
    endtask

    // Entered at a negedge with inputs set; samples ack before the edge and
    // the registered outputs just after it, returns at the next negedge.
    task automatic tick();
        #3;
        obs_ack = bus.ack;
        model_step();
        @(posedge clk);
        #1;
        obs_valid = bus.rsp_valid;
        obs_id    = bus.rsp_id;
        obs_sum   = bus.sum;
        obs_cout  = bus.c_out;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.req = '1;
        for (int i = 0; i < int'(N); i++) set_word(i, 16'h1111, 16'h2222, 1'b1, 1'b1, 1'b1);
        #1 rst = 1'b1;
        #2;
        n_vec++;
        if (bus.ack !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_ack: got %b want 0000", bus.ack);
        end
        n_vec++;
        if ({bus.rsp_valid, bus.rsp_id, bus.sum, bus.c_out} !== 20'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got valid=%b id=%0d sum=%h cout=%b want all zero",
                     bus.rsp_valid, bus.rsp_id, bus.sum, bus.c_out);
        end
        @(negedge clk);
        bus.req = '0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_carry_out();
        set_word(0, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b1);
        tick();
        n_vec++;
        if ({obs_ack, obs_valid, obs_id, obs_sum, obs_cout} !== {4'b0001, 1'b1, 2'd0, 16'h0000, 1'b1}) begin
            n_err++;
            $display("FAIL carry_out: got ack=%b v=%b id=%0d sum=%h co=%b want ack=0001 v=1 id=0 sum=0000 co=1",
                     obs_ack, obs_valid, obs_id, obs_sum, obs_cout);
        end
        bus.req[0] = 1'b0;
        tick();
        n_vec++;
        if ({obs_ack, obs_valid, obs_id, obs_sum, obs_cout} !== {4'b0000, 1'b0, 2'd0, 16'h0000, 1'b1}) begin
            n_err++;
            $display("FAIL idle_hold: got ack=%b v=%b id=%0d sum=%h co=%b want ack=0000 v=0 id=0 sum=0000 co=1",
                     obs_ack, obs_valid, obs_id, obs_sum, obs_cout);
        end
    endtask

    task automatic test_chain();
        logic [3:0]  e_ack [4] = '{4'b0010, 4'b0010, 4'b1000, 4'b0000};
        logic        e_v   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [1:0]  e_id  [4] = '{2'd1, 2'd1, 2'd3, 2'd3};
        logic [15:0] e_sum [4] = '{16'h0000, 16'h0001, 16'h3333, 16'h3333};
        logic        e_co  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        set_word(1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        set_word(3, 16'h1111, 16'h2222, 1'b0, 1'b1, 1'b1);
        for (int c = 0; c < 4; c++) begin
            if (c == 1) set_word(1, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1);
            if (c == 2) bus.req[1] = 1'b0;
            if (c == 3) bus.req[3] = 1'b0;
            tick();
            n_vec++;
            if ({obs_ack, obs_valid, obs_id, obs_sum, obs_cout} !==
                {e_ack[c], e_v[c], e_id[c], e_sum[c], e_co[c]} ||
                {obs_ack, obs_valid, obs_id, obs_sum, obs_cout} !==
                {exp_ack, exp_valid, exp_id, exp_sum, exp_cout}) begin
                n_err++;
                $display("FAIL chain[%0d]: got ack=%b v=%b id=%0d sum=%h co=%b want ack=%b v=%b id=%0d sum=%h co=%b",
                         c, obs_ack, obs_valid, obs_id, obs_sum, obs_cout,
                         e_ack[c], e_v[c], e_id[c], e_sum[c], e_co[c]);
            end
        end
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < int'(N); i++) set_word(i, rnd16(), rnd16(), 1'($urandom_range(0, 1)), 1'b1, 1'b1);
        for (int k = 0; k < 6; k++) begin
            tick();
            n_vec++;
            if (obs_ack !== 4'(1 << (k % 4)) || obs_valid !== 1'b1 ||
                {obs_ack, obs_valid, obs_id, obs_sum, obs_cout} !==
                {exp_ack, exp_valid, exp_id, exp_sum, exp_cout}) begin
                n_err++;
                $display("FAIL round_robin[%0d]: got ack=%b v=%b id=%0d sum=%h co=%b want ack=%b v=1 id=%0d sum=%h co=%b",
                         k, obs_ack, obs_valid, obs_id, obs_sum, obs_cout,
                         4'(1 << (k % 4)), exp_id, exp_sum, exp_cout);
            end
        end
        bus.req = '0;
        tick();
    endtask

    task automatic test_carry_in();
        set_word(2, 16'h1234, 16'h4321, 1'b1, 1'b1, 1'b1);
        tick();
        n_vec++;
        if ({obs_ack, obs_valid, obs_id, obs_sum, obs_cout} !== {4'b0100, 1'b1, 2'd2, 16'h5556, 1'b0}) begin
            n_err++;
            $display("FAIL carry_in: got ack=%b v=%b id=%0d sum=%h co=%b want ack=0100 v=1 id=2 sum=5556 co=0",
                     obs_ack, obs_valid, obs_id, obs_sum, obs_cout);
        end
        bus.req[2] = 1'b0;
        set_word(0, 16'h0010, 16'h0020, 1'b0, 1'b1, 1'b1);
        set_word(1, 16'h0030, 16'h0040, 1'b0, 1'b1, 1'b1);
        set_word(3, 16'h0050, 16'h0060, 1'b0, 1'b1, 1'b1);
        tick();
        n_vec++;
        if (obs_ack !== 4'b1000 || obs_sum !== 16'h00B0 || obs_id !== 2'd3) begin
            n_err++;
            $display("FAIL pointer_after_2: got ack=%b id=%0d sum=%h want ack=1000 id=3 sum=00b0",
                     obs_ack, obs_id, obs_sum);
        end
        bus.req = '0;
        tick();
    endtask

    task automatic test_bubble();
        set_word(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        tick();
        n_vec++;
        if ({obs_ack, obs_valid, obs_sum, obs_cout} !== {4'b0001, 1'b1, 16'h0000, 1'b1}) begin
            n_err++;
            $display("FAIL bubble_lock: got ack=%b v=%b sum=%h co=%b want ack=0001 v=1 sum=0000 co=1",
                     obs_ack, obs_valid, obs_sum, obs_cout);
        end
        bus.req[0] = 1'b0;
        set_word(1, 16'h0007, 16'h0008, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            n_vec++;
            if (obs_ack !== 4'b0000 || obs_valid !== 1'b0 || exp_ack !== 4'b0000) begin
                n_err++;
                $display("FAIL bubble[%0d]: got ack=%b v=%b want ack=0000 v=0", k, obs_ack, obs_valid);
            end
        end
        set_word(0, 16'h0005, 16'h0006, 1'b0, 1'b1, 1'b1);
        tick();
        n_vec++;
        if ({obs_ack, obs_valid, obs_id, obs_sum, obs_cout} !== {4'b0001, 1'b1, 2'd0, 16'h000C, 1'b0}) begin
            n_err++;
            $display("FAIL bubble_resume: got ack=%b v=%b id=%0d sum=%h co=%b want ack=0001 v=1 id=0 sum=000c co=0",
                     obs_ack, obs_valid, obs_id, obs_sum, obs_cout);
        end
        bus.req[0] = 1'b0;
        tick();
        n_vec++;
        if ({obs_ack, obs_valid, obs_id, obs_sum, obs_cout} !== {4'b0010, 1'b1, 2'd1, 16'h000F, 1'b0}) begin
            n_err++;
            $display("FAIL bubble_release: got ack=%b v=%b id=%0d sum=%h co=%b want ack=0010 v=1 id=1 sum=000f co=0",
                     obs_ack, obs_valid, obs_id, obs_sum, obs_cout);
        end
        bus.req = '0;
        tick();
    endtask

    task automatic test_reset_mid_chain();
        set_word(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        tick();
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({bus.ack, bus.rsp_valid, bus.rsp_id, bus.sum, bus.c_out} !== 24'd0) begin
            n_err++;
            $display("FAIL reset_mid_chain: got ack=%b v=%b id=%0d sum=%h co=%b want all zero",
                     bus.ack, bus.rsp_valid, bus.rsp_id, bus.sum, bus.c_out);
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        set_word(0, 16'h0001, 16'h0001, 1'b0, 1'b1, 1'b1);
        set_word(3, 16'h0100, 16'h0100, 1'b0, 1'b1, 1'b1);
        tick();
        n_vec++;
        if ({obs_ack, obs_valid, obs_id, obs_sum, obs_cout} !== {4'b0001, 1'b1, 2'd0, 16'h0002, 1'b0}) begin
            n_err++;
            $display("FAIL after_reset: got ack=%b v=%b id=%0d sum=%h co=%b want ack=0001 v=1 id=0 sum=0002 co=0",
                     obs_ack, obs_valid, obs_id, obs_sum, obs_cout);
        end
        bus.req = '0;
        tick();
    endtask

    // Random traffic; a requester only changes its word after acceptance or while idle.
    task automatic test_random();
        for (int i = 0; i < int'(N); i++) begin
            set_word(i, rnd16(), rnd16(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
        end
        for (int c = 0; c < 400; c++) begin
            tick();
            n_vec++;
            if ({obs_ack, obs_valid, obs_id, obs_sum, obs_cout} !==
                {exp_ack, exp_valid, exp_id, exp_sum, exp_cout}) begin
                n_err++;
                $display("FAIL random[%0d]: got ack=%b v=%b id=%0d sum=%h co=%b want ack=%b v=%b id=%0d sum=%h co=%b",
                         c, obs_ack, obs_valid, obs_id, obs_sum, obs_cout,
                         exp_ack, exp_valid, exp_id, exp_sum, exp_cout);
            end
            for (int i = 0; i < int'(N); i++) begin
                if (exp_ack[i] || !bus.req[i]) begin
                    set_word(i, rnd16(), rnd16(), 1'($urandom_range(0, 1)),
                             1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 7));
                end
            end
        end
        bus.req = '0;
        tick();
    endtask

    initial begin
        bus.req      = '0;
        bus.req_a    = '0;
        bus.req_b    = '0;
        bus.req_cin  = '0;
        bus.req_last = '0;
        test_reset();
        test_carry_out();
        test_chain();
        test_round_robin();
        test_carry_in();
        test_bubble();
        test_reset_mid_chain();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
